// File: rtl/fx_update_sequencer.sv
// Purpose : queue host rate-edge updates and issue them one at a time to the arbitrage Container.
// Latency : an addr-1 write at edge N into an empty queue in IDLE is issued during cycle N+1..N+2.
// Backpr. : a full queue drops new entries and sets sticky overflow; the Container paces issue via container_done.
//
// Optional macro FX_COALESCE_EN: an enqueue whose (src,dst) matches a queued, not-yet-issuing
// entry overwrites that entry's weight in place instead of appending.
//
// Ports: Avalon-MM slave (chipselect/write/read/address/writedata/readdata),
//        Container side (u_src/u_dst/u_e/container_reset/container_done), busy status.
module fx_update_sequencer #(
    parameter int PRED_W   = 6,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [2:0]          address,
    input  logic [WEIGHT_W-1:0] writedata,
    output logic [31:0]         readdata,
    output logic [PRED_W-1:0]   u_src,
    output logic [PRED_W-1:0]   u_dst,
    output logic [WEIGHT_W-1:0] u_e,
    output logic                container_reset,
    input  logic                container_done,
    output logic                busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PRED_W-1:0]   src;
        logic [PRED_W-1:0]   dst;
        logic [WEIGHT_W-1:0] w;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [PRED_W-1:0] stg_src_q, stg_src_d;
    logic [PRED_W-1:0] stg_dst_q, stg_dst_d;
    entry_t            u_q, u_d;

    logic   host_wr, enq, flush, ovf_clr, pop, full, do_push;
    entry_t head, new_entry;
`ifdef FX_COALESCE_EN
    logic          hit;
    logic [AW-1:0] hit_idx, scan_idx;
`endif

    assign host_wr   = chipselect && write;
    assign enq       = host_wr && (address == 3'd1);
    assign flush     = host_wr && (address == 3'd2) && writedata[1];
    assign ovf_clr   = host_wr && (address == 3'd2) && writedata[0];
    // The head always leaves the queue on the single ISSUE cycle.
    assign pop       = (state_q == ST_ISSUE);
    assign full      = (count_q == CW'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign new_entry = '{src: stg_src_q, dst: stg_dst_q, w: writedata};

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        stg_src_d = stg_src_q;
        stg_dst_d = stg_dst_q;
        u_d       = u_q;
        do_push   = 1'b0;

        if (host_wr && (address == 3'd0)) begin
            stg_src_d = writedata[2*PRED_W-1:PRED_W];
            stg_dst_d = writedata[PRED_W-1:0];
        end

`ifdef FX_COALESCE_EN
        // Youngest match wins: later indices overwrite earlier hits. The head
        // is excluded while it is being issued because its data is leaving.
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if ((CW'(i) < count_q) && !((i == 0) && (state_q == ST_ISSUE)) &&
                (mem_q[scan_idx].src == stg_src_q) && (mem_q[scan_idx].dst == stg_dst_q)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
`endif

        if (flush) begin
            // Drops every queued entry; an in-flight update is held in u_q, not the queue.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (enq) begin
`ifdef FX_COALESCE_EN
                if (hit) begin
                    mem_d[hit_idx].w = writedata;
                end else if (!full || pop) begin
                    do_push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
`else
                if (!full || pop) begin
                    do_push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
`endif
            end
            // When full with a pop, the write slot equals the head slot; the head
            // has already been captured into u_q at this same edge.
            if (do_push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(pop);
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A flush landing on the same edge empties the queue, so do not issue.
                if ((count_q != '0) && !flush) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                u_d     = head;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (container_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            stg_src_q <= '0;
            stg_dst_q <= '0;
            u_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            stg_src_q <= stg_src_d;
            stg_dst_q <= stg_dst_d;
            u_q       <= u_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign container_reset = (state_q == ST_ISSUE);
    // The head is stable during ISSUE, so it drives the Container directly then.
    assign u_src = (state_q == ST_ISSUE) ? head.src : u_q.src;
    assign u_dst = (state_q == ST_ISSUE) ? head.dst : u_q.dst;
    assign u_e   = (state_q == ST_ISSUE) ? head.w   : u_q.w;

    assign readdata = (chipselect && read && (address == 3'd3)) ?
                      {ovf_q, busy, {(32-2-CW){1'b0}}, count_q} : 32'd0;

endmodule

// File: tb/tb_fx_update_sequencer.sv
// Purpose : randomized and directed check of fx_update_sequencer against a queue-based model.
// Latency : model predicts outputs cycle by cycle from the abstract issue/wait rules.
// Backpr. : bench drives container_done manually, randomly, or after a fixed delay.
module tb_fx_update_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect, write, read, container_done;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [5:0]  u_src, u_dst;
    logic [31:0] u_e;
    logic        container_reset, busy;

    always #5 clk = ~clk;

    fx_update_sequencer #(.PRED_W(6), .WEIGHT_W(32), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata), .readdata(readdata),
        .u_src(u_src), .u_dst(u_dst), .u_e(u_e), .container_reset(container_reset),
        .container_done(container_done), .busy(busy)
    );

    typedef struct { logic [5:0] s; logic [5:0] d; logic [31:0] w; } ent_t;

    // Reference model: a plain queue plus "issuing this cycle" / "update in flight" flags.
    ent_t        mq[$];
    bit          m_issuing, m_inflight, m_ovf;
    ent_t        m_u;
    logic [5:0]  m_ss, m_sd;
    int          wait_cnt;

    int          checks = 0;
    int          failures = 0;
    int          done_mode = 0;   // 0 manual, 1 random, 2 fixed delay
    int          done_delay = 0;
    logic [31:0] issued_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_issuing = 0; m_inflight = 0; m_ovf = 0;
        m_u = '{s: 6'd0, d: 6'd0, w: 32'd0};
        m_ss = '0; m_sd = '0; wait_cnt = 0;
    endtask

    function automatic logic [31:0] exp_readdata();
        logic [31:0] r;
        r = 32'd0;
        if (chipselect && read && address == 3'd3) begin
            r[31]  = m_ovf;
            r[30]  = m_issuing || m_inflight;
            r[3:0] = 4'(mq.size());
        end
        return r;
    endfunction

    task automatic model_step();
        bit   w, pop, flush, merged, nxt_issuing, nxt_inflight;
        int   n0;
        ent_t hd, t;
        w     = chipselect && write;
        pop   = m_issuing;
        n0    = mq.size();
        flush = w && address == 3'd2 && writedata[1];
        if (pop) hd = mq[0];
        if (flush) begin
            mq.delete();
        end else if (w && address == 3'd1) begin
            merged = 0;
`ifdef FX_COALESCE_EN
            for (int k = mq.size() - 1; k >= (pop ? 1 : 0); k--) begin
                if (!merged && mq[k].s == m_ss && mq[k].d == m_sd) begin
                    t = mq[k]; t.w = writedata; mq[k] = t; merged = 1;
                end
            end
`endif
            if (!merged) begin
                if (n0 < 8 || pop) begin
                    t.s = m_ss; t.d = m_sd; t.w = writedata;
                    mq.push_back(t);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (pop) begin
            m_u = hd;
            if (!flush) void'(mq.pop_front());
        end
        if (w && address == 3'd2 && writedata[0]) m_ovf = 0;
        if (w && address == 3'd0) begin
            m_ss = writedata[11:6];
            m_sd = writedata[5:0];
        end
        nxt_issuing  = !m_issuing && !m_inflight && n0 > 0 && !flush;
        nxt_inflight = m_issuing || (m_inflight && !container_done);
        wait_cnt     = (nxt_inflight && m_inflight) ? wait_cnt + 1 : 0;
        m_issuing    = nxt_issuing;
        m_inflight   = nxt_inflight;
    endtask

    // Called at a negedge with inputs set: compares every output, then advances one clock.
    task automatic tick();
        if (done_mode == 1) container_done = ($urandom_range(0, 3) == 0);
        else if (done_mode == 2) container_done = m_inflight && (wait_cnt >= done_delay);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_issuing || m_inflight});
        chk("container_reset", {31'd0, container_reset}, {31'd0, m_issuing});
        chk("u_src", {26'd0, u_src}, {26'd0, m_issuing ? mq[0].s : m_u.s});
        chk("u_dst", {26'd0, u_dst}, {26'd0, m_issuing ? mq[0].d : m_u.d});
        chk("u_e", u_e, m_issuing ? mq[0].w : m_u.w);
        chk("readdata", readdata, exp_readdata());
        if (container_reset === 1'b1) issued_log.push_back(u_e);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        tick();
        chipselect = 0; write = 0; address = 3'd0; writedata = 32'd0;
    endtask

    task automatic host_update(input int s, input int d, input logic [31:0] wgt);
        host_write(3'd0, 32'((s << 6) | d));
        host_write(3'd1, wgt);
    endtask

    task automatic status_read(input string name, input logic [31:0] exp);
        chipselect = 1; read = 1; address = 3'd3;
        #1 chk(name, readdata, exp);
        tick();
        chipselect = 0; read = 0; address = 3'd0;
    endtask

    task automatic drain();
        done_mode = 1;
        for (int i = 0; i < 400 && (mq.size() > 0 || m_issuing || m_inflight); i++) tick();
        repeat (2) tick();
        chk("drain_idle", {31'd0, busy}, 32'd0);
        done_mode = 0; container_done = 0;
    endtask

    initial begin
        reset_n = 0; chipselect = 0; write = 0; read = 0; address = 3'd0;
        writedata = 32'd0; container_done = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_u_e", u_e, 32'd0);
        reset_n = 1;

        // Single update: issue visible on the second cycle after the addr-1 write.
        host_update(2, 5, 32'h1000);
        chk("single_pre_issue", {31'd0, container_reset}, 32'd0);
        tick();
        chk("single_cr", {31'd0, container_reset}, 32'd1);
        chk("single_src", {26'd0, u_src}, 32'd2);
        chk("single_dst", {26'd0, u_dst}, 32'd5);
        chk("single_e", u_e, 32'h1000);
        repeat (4) tick();
        chk("single_busy_wait", {31'd0, busy}, 32'd1);
        container_done = 1; tick(); container_done = 0;
        tick();
        chk("single_idle", {31'd0, busy}, 32'd0);
        chk("single_hold_e", u_e, 32'h1000);

        // Ordering with a 20-cycle Container.
        issued_log.delete();
        done_mode = 2; done_delay = 20;
        host_update(1, 2, 32'd10);
        host_update(3, 4, 32'd20);
        host_update(5, 6, 32'd30);
        drain();
        chk("order_n", 32'(issued_log.size()), 32'd3);
        if (issued_log.size() == 3) begin
            chk("order_0", issued_log[0], 32'd10);
            chk("order_1", issued_log[1], 32'd20);
            chk("order_2", issued_log[2], 32'd30);
        end

        // Overflow: done held low, 10 distinct updates, one goes in flight.
        for (int i = 0; i < 10; i++) host_update(i + 20, i + 30, 32'(i + 1));
        status_read("ovf_status", 32'hC000_0008);
        host_write(3'd2, 32'd1);
        status_read("ovf_cleared", 32'h4000_0008);
        drain();

        // Flush with 4 queued during WAIT.
        for (int i = 0; i < 5; i++) host_update(i + 40, i + 1, 32'(100 + i));
        status_read("flush_before", 32'h4000_0004);
        host_write(3'd2, 32'd2);
        status_read("flush_after", 32'h4000_0000);
        issued_log.delete();
        container_done = 1; tick(); container_done = 0;
        repeat (6) tick();
        chk("flush_no_issue", 32'(issued_log.size()), 32'd0);
        chk("flush_idle", {31'd0, busy}, 32'd0);

        // Coalescing of a repeated (src,dst) while in WAIT.
        host_update(7, 7, 32'd1);
        repeat (2) tick();
        host_update(1, 3, 32'd100);
        host_write(3'd1, 32'd200);
`ifdef FX_COALESCE_EN
        status_read("coal_count", 32'h4000_0001);
`else
        status_read("coal_count", 32'h4000_0002);
`endif
        issued_log.delete();
        done_mode = 2; done_delay = 3;
        drain();
`ifdef FX_COALESCE_EN
        chk("coal_n", 32'(issued_log.size()), 32'd1);
        if (issued_log.size() == 1) chk("coal_e", issued_log[0], 32'd200);
`else
        chk("coal_n", 32'(issued_log.size()), 32'd2);
        if (issued_log.size() == 2) begin
            chk("coal_e0", issued_log[0], 32'd100);
            chk("coal_e1", issued_log[1], 32'd200);
        end
`endif

        // Asynchronous reset mid-WAIT with three queued.
        for (int i = 0; i < 4; i++) host_update(i + 50, i + 9, 32'(500 + i));
        repeat (2) tick();
        #2 reset_n = 0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cr", {31'd0, container_reset}, 32'd0);
        chk("arst_u", {u_src, u_dst, 20'd0}, 32'd0);
        chk("arst_e", u_e, 32'd0);
        chipselect = 1; read = 1; address = 3'd3;
        #1 chk("arst_status", readdata, 32'd0);
        chipselect = 0; read = 0; address = 3'd0;
        model_reset();
        @(negedge clk);
        reset_n = 1;

        // Randomized traffic with small node ranges so coalescing and overflow occur.
        for (int c = 0; c < 1500; c++) begin
            int op;
            if (c % 200 == 0) done_mode = $urandom_range(1, 2);
            done_delay = $urandom_range(0, 6);
            op = $urandom_range(0, 9);
            chipselect = 0; write = 0; read = 0; address = 3'd0; writedata = 32'd0;
            case (op)
                3: begin chipselect = 1; write = 1; address = 3'd0;
                         writedata = 32'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3)); end
                4, 5: begin chipselect = 1; write = 1; address = 3'd1; writedata = $urandom; end
                6: begin chipselect = 1; write = 1; address = 3'd2;
                         writedata = {30'd0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))}; end
                7: begin chipselect = 1'($urandom_range(0, 1)); read = 1; address = 3'($urandom_range(0, 7)); end
                8: begin chipselect = 1; write = 1; address = 3'($urandom_range(4, 7)); writedata = $urandom; end
                9: begin chipselect = 1; read = 1; address = 3'd3; end
                default: ;
            endcase
            tick();
        end
        chipselect = 0; write = 0; read = 0; address = 3'd0; writedata = 32'd0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
